// File: rtl/alu_writeback_if.sv
// Handshake bundle between the ALU and the writeback buffer.
// The master drives ALU results and takes buffered results; the slave is alu_writeback.
interface alu_writeback_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] alu_out;
  logic                  alu_oc;
  logic                  alu_oo;
  logic                  store_carry;
  logic                  store_overflow;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_result;
  logic                  out_carry;
  logic                  out_overflow;

  modport master (
    output in_valid, alu_out, alu_oc, alu_oo, store_carry, store_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_overflow
  );

  modport slave (
    input  in_valid, alu_out, alu_oc, alu_oo, store_carry, store_overflow, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_overflow
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback: commits carry/overflow flags and buffers results in a
// 2-entry FIFO so the stack writeback can stall without losing results.
// The committed carry is a plain register fed back to decode (no forward path).
module alu_writeback #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  alu_writeback_if.slave      bus,
  input  logic                flags_load,
  input  logic [1:0]          flags_load_val,
  output logic                carry,
  output logic                overflow
);

  logic                  acc;
  logic                  pop;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  carry_next;
  logic                  overflow_next;
  logic [WORD_WIDTH-1:0] mem_result   [2];
  logic                  mem_carry    [2];
  logic                  mem_overflow [2];

  // Handshake status from registered occupancy only; ready is held low while reset is asserted
  always_comb begin
    bus.in_ready     = !reset && (count != 2'd2);
    bus.out_valid    = (count != 2'd0);
    bus.out_result   = mem_result[rd_ptr];
    bus.out_carry    = mem_carry[rd_ptr];
    bus.out_overflow = mem_overflow[rd_ptr];
  end

  // Transfer strobes and next flag/occupancy values; flags_load outranks the ALU strobes
  always_comb begin
    acc           = bus.in_valid && bus.in_ready;
    pop           = bus.out_valid && bus.out_ready;
    carry_next    = carry;
    overflow_next = overflow;
    count_next    = count;
    if (flags_load) begin
      carry_next    = flags_load_val[0];
      overflow_next = flags_load_val[1];
    end else if (acc) begin
      if (bus.store_carry)    carry_next    = bus.alu_oc;
      if (bus.store_overflow) overflow_next = bus.alu_oo;
    end
    case ({acc, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Flag registers, FIFO pointers/occupancy and storage; new entries snapshot post-update flags
  always_ff @(posedge clk) begin
    if (reset) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_result[i]   <= '0;
        mem_carry[i]    <= 1'b0;
        mem_overflow[i] <= 1'b0;
      end
    end else begin
      carry    <= carry_next;
      overflow <= overflow_next;
      count    <= count_next;
      if (acc) begin
        mem_result[wr_ptr]   <= bus.alu_out;
        mem_carry[wr_ptr]    <= carry_next;
        mem_overflow[wr_ptr] <= overflow_next;
        wr_ptr               <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus a
// scoreboard that tracks accepted results and expected flag snapshots.
module tb_alu_writeback;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] result;
    logic         c;
    logic         o;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flags_load;
  logic [1:0] flags_load_val;
  logic       carry;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  entry_t sb[$];
  logic   model_c = 1'b0;
  logic   model_o = 1'b0;

  alu_writeback_if #(.WORD_WIDTH(W)) bus ();

  alu_writeback #(.WORD_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .flags_load     (flags_load),
    .flags_load_val (flags_load_val),
    .carry          (carry),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare popped heads, then model the flag commit and push accepted entries
  always @(negedge clk) begin
    entry_t exp;
    if (reset) begin
      sb.delete();
      model_c = 1'b0;
      model_o = 1'b0;
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_pop: unexpected output result=%h c=%b o=%b with empty scoreboard",
                   bus.out_result, bus.out_carry, bus.out_overflow);
        end else begin
          exp = sb.pop_front();
          if ({bus.out_result, bus.out_carry, bus.out_overflow} !== {exp.result, exp.c, exp.o}) begin
            errors++;
            $display("[TB] FAIL sb_entry: got result=%h c=%b o=%b, want result=%h c=%b o=%b",
                     bus.out_result, bus.out_carry, bus.out_overflow, exp.result, exp.c, exp.o);
          end
        end
      end
      if (flags_load) begin
        model_c = flags_load_val[0];
        model_o = flags_load_val[1];
      end else if (bus.in_valid && bus.in_ready) begin
        if (bus.store_carry)    model_c = bus.alu_oc;
        if (bus.store_overflow) model_o = bus.alu_oo;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        exp.result = bus.alu_out;
        exp.c      = model_c;
        exp.o      = model_o;
        sb.push_back(exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.alu_out        = '0;
    bus.alu_oc         = 1'b0;
    bus.alu_oo         = 1'b0;
    bus.store_carry    = 1'b0;
    bus.store_overflow = 1'b0;
    flags_load         = 1'b0;
    flags_load_val     = 2'b00;
  endtask

  // Lets the buffer drain with out_ready high; ok is low if it never empties
  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (bus.out_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;
    sample();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready_during: got %b want 0", bus.in_ready);
    end
    tick();
    reset = 1'b0;
    sample();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_result, bus.out_carry, bus.out_overflow, carry, overflow}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b res=%h oc=%b oo=%b c=%b o=%b, want rdy=1 vld=0 res=0 oc=0 oo=0 c=0 o=0",
               bus.in_ready, bus.out_valid, bus.out_result, bus.out_carry, bus.out_overflow, carry, overflow);
    end
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_out     = 32'hFFFF_FFFF;
    bus.alu_oc      = 1'b1;
    bus.store_carry = 1'b1;
    tick();
    idle_inputs();
    sample();
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_carry, carry} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL basic_latency: got vld=%b res=%h oc=%b c=%b, want vld=1 res=ffffffff oc=1 c=1",
               bus.out_valid, bus.out_result, bus.out_carry, carry);
    end
    tick();
    sample();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_drained: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
    wait_empty(ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL basic_timeout: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
  endtask

  task automatic test_fill_order();
    bit ok;
    bit took;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_out   = 32'h1;
    tick();
    bus.alu_out = 32'h2;
    tick();
    bus.alu_out = 32'h3;
    sample();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_result} !== {1'b0, 1'b1, 32'h1}) begin
      errors++;
      $display("[TB] FAIL fill_full: got rdy=%b vld=%b res=%h, want rdy=0 vld=1 res=1",
               bus.in_ready, bus.out_valid, bus.out_result);
    end
    tick();
    sample();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_hold: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    bus.out_ready = 1'b1;
    took = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (bus.in_ready === 1'b1) begin
        took = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!took) begin
      errors++; $display("[TB] FAIL fill_ready_timeout: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    idle_inputs();
    wait_empty(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL fill_drain: got empty=%b pending=%0d, want empty=1 pending=0", ok, sb.size());
    end
    tick();
  endtask

  task automatic test_strobes();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready      = 1'b1;
    bus.in_valid       = 1'b1;
    bus.alu_out        = 'x;
    bus.alu_oc         = 1'b1;
    bus.alu_oo         = 1'b1;
    tick();
    bus.alu_out = 32'h10;
    bus.alu_oc  = 1'bx;
    bus.alu_oo  = 1'bx;
    tick();
    idle_inputs();
    sample();
    checks++;
    if ({carry, overflow} !== 2'b00) begin
      errors++; $display("[TB] FAIL strobe_off: got c=%b o=%b want c=0 o=0", carry, overflow);
    end
    bus.store_carry    = 1'b1;
    bus.store_overflow = 1'b1;
    bus.alu_oc         = 1'b1;
    bus.alu_oo         = 1'b1;
    tick();
    sample();
    checks++;
    if ({carry, overflow} !== 2'b00) begin
      errors++; $display("[TB] FAIL strobe_no_acc: got c=%b o=%b want c=0 o=0", carry, overflow);
    end
    bus.in_valid    = 1'b1;
    bus.alu_out     = 32'h20;
    bus.store_carry = 1'b0;
    tick();
    idle_inputs();
    sample();
    checks++;
    if ({carry, overflow} !== 2'b01) begin
      errors++; $display("[TB] FAIL strobe_ovf_only: got c=%b o=%b want c=0 o=1", carry, overflow);
    end
    tick();
  endtask

  task automatic test_flags_load();
    bit ok;
    wait_empty(ok);
    tick();
    bus.out_ready      = 1'b0;
    flags_load         = 1'b1;
    flags_load_val     = 2'b10;
    bus.in_valid       = 1'b1;
    bus.alu_out        = 32'h55;
    bus.store_carry    = 1'b1;
    bus.alu_oc         = 1'b1;
    tick();
    idle_inputs();
    sample();
    checks++;
    if ({carry, overflow, bus.out_carry, bus.out_overflow, bus.out_result} !== {1'b0, 1'b1, 1'b0, 1'b1, 32'h55}) begin
      errors++;
      $display("[TB] FAIL load_priority: got c=%b o=%b oc=%b oo=%b res=%h, want c=0 o=1 oc=0 oo=1 res=55",
               carry, overflow, bus.out_carry, bus.out_overflow, bus.out_result);
    end
    flags_load     = 1'b1;
    flags_load_val = 2'b01;
    tick();
    idle_inputs();
    sample();
    checks++;
    if ({carry, overflow} !== 2'b10) begin
      errors++; $display("[TB] FAIL load_only: got c=%b o=%b want c=1 o=0", carry, overflow);
    end
    tick();
    wait_empty(ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL load_drain: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_out   = 32'h11;
    tick();
    bus.out_ready = 1'b1;
    bus.alu_out   = 32'hA5;
    sample();
    checks++;
    if ({bus.in_ready, bus.out_result} !== {1'b1, 32'h11}) begin
      errors++;
      $display("[TB] FAIL b2b_pre: got rdy=%b res=%h want rdy=1 res=11", bus.in_ready, bus.out_result);
    end
    tick();
    idle_inputs();
    bus.out_ready = 1'b0;
    sample();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_result} !== {1'b1, 1'b1, 32'hA5}) begin
      errors++;
      $display("[TB] FAIL b2b_replace: got vld=%b rdy=%b res=%h want vld=1 rdy=1 res=a5",
               bus.out_valid, bus.in_ready, bus.out_result);
    end
    tick();
    wait_empty(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got empty=%b pending=%0d want empty=1 pending=0", ok, sb.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.store_carry = 1'b1;
    bus.alu_oc      = 1'b1;
    bus.alu_out     = 32'hDEAD_0001;
    tick();
    bus.alu_out = 32'hDEAD_0002;
    tick();
    idle_inputs();
    sample();
    checks++;
    if ({bus.in_ready, bus.out_valid, carry} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL mid_full: got rdy=%b vld=%b c=%b want rdy=0 vld=1 c=1", bus.in_ready, bus.out_valid, carry);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    checks++;
    if ({bus.out_valid, bus.out_result, carry, overflow, bus.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mid_reset: got vld=%b res=%h c=%b o=%b rdy=%b want vld=0 res=0 c=0 o=0 rdy=1",
               bus.out_valid, bus.out_result, carry, overflow, bus.in_ready);
    end
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_fill_order();
    test_strobes();
    test_flags_load();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
